// File: rtl/kv_bus_pkg.sv
// Shared types for the key-value store bus: opcodes, per-op bus control decode,
// and the initiator state encoding.
package kv_bus_pkg;

    localparam int unsigned AW_DEF = 7;
    localparam int unsigned DW_DEF = 7;

    typedef enum logic [2:0] {
        OP_INSERT       = 3'd0,
        OP_WRITE_KEY_AT = 3'd1,
        OP_WRITE_VAL_AT = 3'd2,
        OP_LOOKUP_KEY   = 3'd3,
        OP_LOOKUP_VAL   = 3'd4,
        OP_READ_SLOT    = 3'd5,
        OP_ILLEGAL_6    = 3'd6,
        OP_ILLEGAL_7    = 3'd7
    } kv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_RESP = 2'd3
    } kv_state_e;

    // use_adr/use_dat select whether the command field is forwarded or forced to 0
    typedef struct packed {
        logic we;
        logic adr_is_key;
        logic dat_is_key;
        logic use_adr;
        logic use_dat;
    } kv_ctl_t;

    localparam kv_ctl_t CTL_INSERT       = '{we: 1'b1, adr_is_key: 1'b1, dat_is_key: 1'b0, use_adr: 1'b1, use_dat: 1'b1};
    localparam kv_ctl_t CTL_WRITE_KEY_AT = '{we: 1'b1, adr_is_key: 1'b0, dat_is_key: 1'b1, use_adr: 1'b1, use_dat: 1'b1};
    localparam kv_ctl_t CTL_WRITE_VAL_AT = '{we: 1'b1, adr_is_key: 1'b0, dat_is_key: 1'b0, use_adr: 1'b1, use_dat: 1'b1};
    localparam kv_ctl_t CTL_LOOKUP_KEY   = '{we: 1'b0, adr_is_key: 1'b1, dat_is_key: 1'b0, use_adr: 1'b1, use_dat: 1'b0};
    localparam kv_ctl_t CTL_LOOKUP_VAL   = '{we: 1'b0, adr_is_key: 1'b0, dat_is_key: 1'b0, use_adr: 1'b0, use_dat: 1'b1};
    localparam kv_ctl_t CTL_READ_SLOT    = '{we: 1'b0, adr_is_key: 1'b0, dat_is_key: 1'b0, use_adr: 1'b1, use_dat: 1'b0};

    function automatic logic op_is_illegal(input logic [2:0] op);
        return op > 3'(OP_READ_SLOT);
    endfunction

    function automatic kv_ctl_t op_decode(input logic [2:0] op);
        case (kv_op_e'(op))
            OP_INSERT:       return CTL_INSERT;
            OP_WRITE_KEY_AT: return CTL_WRITE_KEY_AT;
            OP_WRITE_VAL_AT: return CTL_WRITE_VAL_AT;
            OP_LOOKUP_KEY:   return CTL_LOOKUP_KEY;
            OP_LOOKUP_VAL:   return CTL_LOOKUP_VAL;
            OP_READ_SLOT:    return CTL_READ_SLOT;
            default:         return '0;
        endcase
    endfunction

endpackage

// File: rtl/keyvalue_initiator_if.sv
// Key-value store bus: initiator drives the _o signals, responder drives the _i signals.
interface keyvalue_initiator_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 7
);
    logic [3:0]    SEL_o;
    logic          ADR_IS_KEY_o;
    logic          DAT_IS_KEY_o;
    logic [AW-1:0] ADR_o;
    logic [DW-1:0] DAT_o;
    logic          WE_o;
    logic          STB_o;
    logic          CYC_o;
    logic          ACK_i;
    logic          STALL_i;
    logic [DW-1:0] DAT_i;
    logic          DUP_i;

    modport master (
        output SEL_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o, WE_o, STB_o, CYC_o,
        input  ACK_i, STALL_i, DAT_i, DUP_i
    );

    modport slave (
        input  SEL_o, ADR_IS_KEY_o, DAT_IS_KEY_o, ADR_o, DAT_o, WE_o, STB_o, CYC_o,
        output ACK_i, STALL_i, DAT_i, DUP_i
    );
endinterface

// File: rtl/kv_watchdog.sv
// Saturating strobe watchdog: counts REQ cycles, flags expiry at TIMEOUT-1.
module kv_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keyvalue_initiator.sv
// Key-value bus initiator: one host command becomes one strobed bus cycle,
// completed by ACK or aborted by the watchdog, then returned as a response.
module keyvalue_initiator
    import kv_bus_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [AW-1:0]         cmd_adr,
    input  logic [DW-1:0]         cmd_dat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_dup,
    output logic                  rsp_err,
    keyvalue_initiator_if.master  bus
);
    kv_state_e     state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic          aik_q, aik_d;
    logic          dik_q, dik_d;
    logic          stb_q, stb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_dup_q, rsp_dup_d;
    logic          rsp_err_q, rsp_err_d;
    logic          wd_clr, wd_en, wd_expired;
    kv_ctl_t       ctl;

    kv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    assign ctl = op_decode(cmd_op);

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        aik_d       = aik_q;
        dik_d       = dik_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_dup_d   = rsp_dup_q;
        rsp_err_d   = rsp_err_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op_is_illegal(cmd_op)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_dup_d   = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        adr_d   = ctl.use_adr ? cmd_adr : '0;
                        dat_d   = ctl.use_dat ? cmd_dat : '0;
                        we_d    = ctl.we;
                        aik_d   = ctl.adr_is_key;
                        dik_d   = ctl.dat_is_key;
                        state_d = ST_WAIT;
                    end
                end
            end
            // Hold off the strobe while a stale ACK or STALL is present
            ST_WAIT: begin
                if (!bus.ACK_i && !bus.STALL_i) begin
                    stb_d   = 1'b1;
                    wd_clr  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.ACK_i || wd_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !bus.ACK_i;
                    rsp_data_d  = bus.ACK_i ? bus.DAT_i : '0;
                    rsp_dup_d   = bus.ACK_i && bus.DUP_i;
                    stb_d       = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    we_d        = 1'b0;
                    aik_d       = 1'b0;
                    dik_d       = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            aik_q       <= 1'b0;
            dik_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_dup_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            aik_q       <= aik_d;
            dik_q       <= dik_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dup_q   <= rsp_dup_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready        = (state_q == ST_IDLE);
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_dup          = rsp_dup_q;
    assign rsp_err          = rsp_err_q;
    assign bus.SEL_o        = 4'hF;
    assign bus.ADR_IS_KEY_o = aik_q;
    assign bus.DAT_IS_KEY_o = dik_q;
    assign bus.ADR_o        = adr_q;
    assign bus.DAT_o        = dat_q;
    assign bus.WE_o         = we_q;
    assign bus.STB_o        = stb_q;
    assign bus.CYC_o        = stb_q;
endmodule

// File: tb/tb_keyvalue_initiator.sv
// Directed bench for keyvalue_initiator: table of single transactions plus
// hand-written stale-ACK, backpressure and reset-during-strobe sequences.
module tb_keyvalue_initiator;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 7;
    localparam int unsigned TO = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic          rsp_valid, rsp_ready, rsp_dup, rsp_err;
    logic [DW-1:0] rsp_data;

    keyvalue_initiator_if #(.AW(AW), .DW(DW)) bus ();

    keyvalue_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_dup   (rsp_dup),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // d = extra strobe cycles before ACK (STB high d+1 cycles); -1 = never ACK
    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            d;
        logic [DW-1:0] ack_dat;
        logic          ack_dup;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic          e_we, e_aik, e_dik;
        logic [DW-1:0] e_data;
        logic          e_dup, e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                           input logic we, input logic aik, input logic dik);
        chk({tag, ".ADR_o"}, 32'(bus.ADR_o), 32'(a));
        chk({tag, ".DAT_o"}, 32'(bus.DAT_o), 32'(dt));
        chk({tag, ".WE_o"}, 32'(bus.WE_o), 32'(we));
        chk({tag, ".ADR_IS_KEY_o"}, 32'(bus.ADR_IS_KEY_o), 32'(aik));
        chk({tag, ".DAT_IS_KEY_o"}, 32'(bus.DAT_IS_KEY_o), 32'(dik));
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        bus.ACK_i = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".rsp_valid_after_ready"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".cmd_ready_after_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_adr = v.adr; cmd_dat = v.dat;
        tick();
        cmd_valid = 1'b0;
        chk({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        if (v.op > 3'd5) begin
            chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".STB_o"}, 32'(bus.STB_o), 32'd0);
            tick();
            chk({tag, ".STB_o_resp"}, 32'(bus.STB_o), 32'd0);
        end else begin
            chk({tag, ".STB_o_wait"}, 32'(bus.STB_o), 32'd0);
            chk_bus({tag, ".wait"}, v.e_adr, v.e_dat, v.e_we, v.e_aik, v.e_dik);
            tick();
            chk({tag, ".STB_o_req"}, 32'(bus.STB_o), 32'd1);
            chk({tag, ".CYC_o_req"}, 32'(bus.CYC_o), 32'd1);
            chk_bus({tag, ".req"}, v.e_adr, v.e_dat, v.e_we, v.e_aik, v.e_dik);
            if (v.d < 0) begin
                n = 1;
                while (bus.STB_o && n < 3 * TO) begin
                    tick();
                    if (bus.STB_o) n++;
                end
                chk({tag, ".stb_high_cycles"}, 32'(n), 32'(TO));
            end else begin
                for (int i = 0; i < v.d; i++) begin
                    tick();
                    chk({tag, ".STB_o_hold"}, 32'(bus.STB_o), 32'd1);
                end
                bus.ACK_i = 1'b1; bus.DAT_i = v.ack_dat; bus.DUP_i = v.ack_dup;
                tick();
                bus.ACK_i = 1'b0;
            end
            chk({tag, ".STB_o_done"}, 32'(bus.STB_o), 32'd0);
            chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk_bus({tag, ".resp"}, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(v.e_data));
        chk({tag, ".rsp_dup"}, 32'(rsp_dup), 32'(v.e_dup));
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(v.e_err));
        consume(tag);
    endtask

    vec_t vecs [10];

    initial begin
        //          op    adr    dat    d   ackdat ackdup e_adr  e_dat  we   aik  dik  e_data e_dup e_err
        vecs[0] = '{3'd0, 7'd5,  7'd9,  2,  7'd1,  1'b0, 7'd5,  7'd9,  1'b1,1'b1,1'b0, 7'd1,  1'b0, 1'b0};
        vecs[1] = '{3'd1, 7'd3,  7'h11, 0,  7'h00, 1'b0, 7'd3,  7'h11, 1'b1,1'b0,1'b1, 7'h00, 1'b0, 1'b0};
        vecs[2] = '{3'd2, 7'd4,  7'h22, 1,  7'h05, 1'b1, 7'd4,  7'h22, 1'b1,1'b0,1'b0, 7'h05, 1'b1, 1'b0};
        vecs[3] = '{3'd3, 7'd3,  7'h55, -1, 7'h7F, 1'b1, 7'd3,  7'h00, 1'b0,1'b1,1'b0, 7'h00, 1'b0, 1'b1};
        vecs[4] = '{3'd4, 7'h6A, 7'h33, 3,  7'h44, 1'b0, 7'h00, 7'h33, 1'b0,1'b0,1'b0, 7'h44, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 7'd2,  7'h19, 0,  7'h2A, 1'b0, 7'd2,  7'h00, 1'b0,1'b0,1'b0, 7'h2A, 1'b0, 1'b0};
        vecs[6] = '{3'd6, 7'd1,  7'd1,  0,  7'h00, 1'b0, 7'd0,  7'h00, 1'b0,1'b0,1'b0, 7'h00, 1'b0, 1'b1};
        vecs[7] = '{3'd7, 7'h7F, 7'h7F, 0,  7'h00, 1'b0, 7'd0,  7'h00, 1'b0,1'b0,1'b0, 7'h00, 1'b0, 1'b1};
        // ACK on the watchdog's final cycle beats the timeout; one earlier is plain ACK
        vecs[8] = '{3'd3, 7'd8,  7'h00, 15, 7'h3C, 1'b1, 7'd8,  7'h00, 1'b0,1'b1,1'b0, 7'h3C, 1'b1, 1'b0};
        vecs[9] = '{3'd5, 7'd9,  7'h00, 14, 7'h12, 1'b0, 7'd9,  7'h00, 1'b0,1'b0,1'b0, 7'h12, 1'b0, 1'b0};

        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b0;
        bus.ACK_i = 1'b0; bus.STALL_i = 1'b0; bus.DAT_i = '0; bus.DUP_i = 1'b0;
        #12;
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.STB_o", 32'(bus.STB_o), 32'd0);
        chk("reset.CYC_o", 32'(bus.CYC_o), 32'd0);
        chk("reset.SEL_o", 32'(bus.SEL_o), 32'hF);
        chk("reset.rsp_fields", 32'({rsp_data, rsp_dup, rsp_err}), 32'd0);
        chk_bus("reset", '0, '0, 1'b0, 1'b0, 1'b0);
        #2 sys_rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Stale ACK for 4 cycles, then STALL for 2: strobe waits for both to clear
        bus.ACK_i = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_adr = 7'd6; cmd_dat = 7'h0F;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stale.STB_o_low", 32'(bus.STB_o), 32'd0);
            tick();
        end
        bus.ACK_i = 1'b0; bus.STALL_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall.STB_o_low", 32'(bus.STB_o), 32'd0);
        end
        bus.STALL_i = 1'b0;
        tick();
        chk("stale.STB_o_high", 32'(bus.STB_o), 32'd1);
        chk_bus("stale.req", 7'd6, 7'h0F, 1'b1, 1'b0, 1'b0);
        bus.ACK_i = 1'b1; bus.DAT_i = 7'h07; bus.DUP_i = 1'b0;
        tick();
        bus.ACK_i = 1'b0;
        chk("stale.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stale.rsp_data", 32'(rsp_data), 32'h07);
        chk("stale.rsp_err", 32'(rsp_err), 32'd0);
        consume("stale");

        // READ_SLOT with response held off for 5 cycles
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_adr = 7'd2; cmd_dat = 7'h00;
        tick();
        cmd_valid = 1'b0;
        tick();
        bus.ACK_i = 1'b1; bus.DAT_i = 7'h2A;
        tick();
        bus.ACK_i = 1'b0; bus.DAT_i = 7'h00;
        for (int i = 0; i < 5; i++) begin
            chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp.rsp_data", 32'(rsp_data), 32'h2A);
            chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        consume("bp");

        // Reset during strobe clears outputs without a clock edge
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_adr = 7'd1; cmd_dat = 7'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("rst.STB_o_before", 32'(bus.STB_o), 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk("rst.STB_o_async", 32'(bus.STB_o), 32'd0);
        chk("rst.CYC_o_async", 32'(bus.CYC_o), 32'd0);
        chk("rst.rsp_valid_async", 32'(rsp_valid), 32'd0);
        chk("rst.cmd_ready_async", 32'(cmd_ready), 32'd1);
        #2 sys_rst = 1'b0;
        tick();
        chk("rst.cmd_ready_after", 32'(cmd_ready), 32'd1);
        run_vec("post_rst", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
